// File: rtl/synarray_sweep_ctrl.sv
// Synaptic SRAM sweep sequencer: walks every word of one pre-neuron per accepted event,
// read-only in inference, read/write-back pairs in training, with a registered read-data tag.
module synarray_sweep_ctrl #(
    parameter int N = 784,
    parameter int M = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [9:0]  PRE_NEUR_ADDR,
    input  logic        IS_TRAIN,
    input  logic        SPI_GATE_ACTIVITY_sync,
    output logic        BUSY,
    output logic        DONE,
    output logic        ADDR_ERR,
    output logic        CTRL_SYNARRAY_CS,
    output logic        CTRL_SYNARRAY_WE,
    output logic [15:0] CTRL_SYNARRAY_ADDR,
    output logic [9:0]  CTRL_POST_NEURON_ADDRESS,
    output logic        CTRL_SYNA_RD_EVENT,
    output logic        CTRL_SYNA_WR_EVENT,
    output logic        RDATA_VALID,
    output logic [9:0]  RDATA_POST_BASE,
    output logic [3:0]  RDATA_BYTE_MASK
);

    localparam int WPP   = (M + 3) / 4;
    localparam int IDX_W = (WPP > 1) ? $clog2(WPP) : 1;

    generate
        if (N * WPP > 65536) begin : g_size_chk
            $error("synarray_sweep_ctrl: N*WPP exceeds the 65536-word array");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [15:0]        r_base, w_base_nxt;
    logic               r_train, w_train_nxt;
    logic               w_accept, w_last, w_addr_err_nxt, w_access_nxt;
    logic [15:0]        w_addr_nxt;
    logic [9:0]         w_post_nxt;
    logic [3:0]         w_mask;

    assign w_last       = (r_idx == IDX_W'(WPP - 1));
    assign w_accept     = START && !SPI_GATE_ACTIVITY_sync &&
                          ((r_state == S_IDLE) || (r_state == S_FIN));
    assign w_access_nxt = (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
    assign w_addr_nxt   = w_base_nxt + 16'(w_idx_nxt);
    assign w_post_nxt   = 10'({w_idx_nxt, 2'b00});

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_base_nxt     = r_base;
        w_train_nxt    = r_train;
        w_addr_err_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_FIN: begin
                w_state_nxt = S_IDLE;
                if (w_accept) begin
                    if (32'(PRE_NEUR_ADDR) >= N) begin
                        w_state_nxt    = S_FIN;
                        w_addr_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RD;
                        w_idx_nxt   = '0;
                        w_base_nxt  = 16'(32'(PRE_NEUR_ADDR) * WPP);
                        w_train_nxt = IS_TRAIN;
                    end
                end
            end
            S_RD: begin
                if (r_train) begin
                    w_state_nxt = S_WR;
                end else if (w_last) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_WR: begin
                if (w_last) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_RD;
                    w_idx_nxt   = r_idx + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte b of the word being read is a real synapse only if its post index is below M
    always_comb begin
        w_mask = '0;
        for (int b = 0; b < 4; b++) begin
            w_mask[b] = ((32'(CTRL_POST_NEURON_ADDRESS) + 32'(b)) < 32'(M));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state                  <= S_IDLE;
            r_idx                    <= '0;
            r_base                   <= '0;
            r_train                  <= 1'b0;
            BUSY                     <= 1'b0;
            DONE                     <= 1'b0;
            ADDR_ERR                 <= 1'b0;
            CTRL_SYNARRAY_CS         <= 1'b0;
            CTRL_SYNARRAY_WE         <= 1'b0;
            CTRL_SYNARRAY_ADDR       <= '0;
            CTRL_POST_NEURON_ADDRESS <= '0;
            CTRL_SYNA_RD_EVENT       <= 1'b0;
            CTRL_SYNA_WR_EVENT       <= 1'b0;
            RDATA_VALID              <= 1'b0;
            RDATA_POST_BASE          <= '0;
            RDATA_BYTE_MASK          <= '0;
        end else begin
            r_state            <= w_state_nxt;
            r_idx              <= w_idx_nxt;
            r_base             <= w_base_nxt;
            r_train            <= w_train_nxt;
            BUSY               <= w_access_nxt;
            DONE               <= (w_state_nxt == S_FIN);
            ADDR_ERR           <= w_addr_err_nxt;
            CTRL_SYNARRAY_CS   <= w_access_nxt;
            CTRL_SYNARRAY_WE   <= (w_state_nxt == S_WR);
            CTRL_SYNA_RD_EVENT <= (w_state_nxt == S_RD);
            CTRL_SYNA_WR_EVENT <= (w_state_nxt == S_WR);
            // Address lines keep their last value while the array is deselected
            if (w_access_nxt) begin
                CTRL_SYNARRAY_ADDR       <= w_addr_nxt;
                CTRL_POST_NEURON_ADDRESS <= w_post_nxt;
            end
            RDATA_VALID <= (r_state == S_RD);
            if (r_state == S_RD) begin
                RDATA_POST_BASE <= CTRL_POST_NEURON_ADDRESS;
                RDATA_BYTE_MASK <= w_mask;
            end
        end
    end

endmodule

// File: doc/synarray_sweep_ctrl.md
Name: synarray_sweep_ctrl

Overview:
Initiator-side sequencer for the synaptic SRAM array (65536x32, four 8-bit weights per word, one-cycle registered read). On each accepted pre-synaptic event it sweeps every word belonging to that pre-neuron and drives chip-select, write-enable, word address and post-neuron address.
- Inference: read-only pipelined sweep.
- Training: a read/write-back pair per word, so the per-byte FF-STDP update computed from the read data is written to the same address on the following cycle.
Sits between the event controller and the synaptic core.

Parameters:
N, 784, number of pre-synaptic neurons; valid PRE_NEUR_ADDR range is 0..N-1.
M, 8, number of post-synaptic neurons.
WPP (localparam), (M+3)/4, words per pre-neuron. Elaboration must fail if N*WPP > 65536.

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
START  input  1  one-cycle request to sweep one pre-neuron
PRE_NEUR_ADDR  input  10  pre-neuron index, sampled with START
IS_TRAIN  input  1  sampled with START; 1 = read+write-back, 0 = read only
SPI_GATE_ACTIVITY_sync  input  1  when 1, START is ignored; an in-flight sweep still completes
BUSY  output  1  sweep in progress
DONE  output  1  one-cycle completion pulse
ADDR_ERR  output  1  one-cycle pulse: START rejected because PRE_NEUR_ADDR >= N
CTRL_SYNARRAY_CS  output  1  SRAM chip select
CTRL_SYNARRAY_WE  output  1  SRAM write enable
CTRL_SYNARRAY_ADDR  output  16  SRAM word address
CTRL_POST_NEURON_ADDRESS  output  10  post-neuron index of byte 0 of the current word (word_idx*4)
CTRL_SYNA_RD_EVENT  output  1  1 in read-access cycles
CTRL_SYNA_WR_EVENT  output  1  1 in write-back cycles
RDATA_VALID  output  1  SYNARRAY_RDATA holds the weights of word RDATA_POST_BASE/4 this cycle
RDATA_POST_BASE  output  10  post index of byte 0 of the valid read data
RDATA_BYTE_MASK  output  4  bit b=1 iff RDATA_POST_BASE+b < M

Behaviour:
- Reset: all outputs are 0, state is IDLE. Reset mid-sweep aborts at once. No write is issued in the reset cycle or afterwards, and DONE is not pulsed.
- All outputs are registered. Sweep address is base = pre*WPP, and word address = base + word_idx, with word_idx counting 0..WPP-1.
- Accepting START: accepted only in IDLE with SPI_GATE_ACTIVITY_sync=0. START while BUSY, or while gated, is dropped silently.
- Invalid address: an accepted START with PRE_NEUR_ADDR >= N does not enter a sweep. ADDR_ERR and DONE pulse together the next cycle, with no SRAM access and BUSY staying 0.
- States: IDLE, RD, WR, FIN.
- IDLE: on a valid START, latch pre and mode, set word_idx=0, go to RD.
- RD: CS=1, WE=0, RD_EVENT=1, ADDR=base+word_idx.
  - Train: go to WR.
  - Inference: if word_idx=WPP-1 go to FIN, else increment word_idx and stay in RD (one word per cycle).
- WR (train only): CS=1, WE=1, WR_EVENT=1, with ADDR and POST address identical to the preceding RD cycle. If word_idx=WPP-1 go to FIN, else increment word_idx and go to RD.
- FIN: DONE=1, BUSY=0, CS=0, return to IDLE. A START in the FIN cycle is accepted (back-to-back sweeps).
- BUSY is 1 in RD and WR only.
- RDATA_VALID is asserted the cycle after every RD cycle, with base and mask of that word. In train mode this coincides with the WR cycle, so write data is valid while WE=1.
- Cycle counts: WPP reads take WPP+1 cycles from START to DONE in inference, and 2*WPP+1 cycles in training.
- Partial last word (M not a multiple of 4): the whole word is accessed and written back; out-of-range bytes are marked 0 in RDATA_BYTE_MASK.
- CTRL_SYNARRAY_ADDR and CTRL_POST_NEURON_ADDRESS hold their last value when CS=0.

Test Plan:
1. Reset, then START with pre=5 and IS_TRAIN=0 (M=8):
   - RD at addr 10 (post 0), then RD at addr 11 (post 4);
   - RDATA_VALID in the two following cycles, with base 0 and base 4 and mask 1111;
   - DONE 3 cycles after START; WE never 1.
2. START with pre=783 and IS_TRAIN=1:
   - sequence RD 1566, WR 1566, RD 1567, WR 1567, FIN;
   - DONE on cycle 5; RDATA_VALID coincides with each WR.
3. START with pre=784 -> no CS; ADDR_ERR and DONE together one cycle later; BUSY stays 0.
4. START asserted while BUSY, or with SPI_GATE_ACTIVITY_sync=1 -> ignored, and the ongoing sweep is unaffected. A START in the FIN cycle -> the new sweep begins next cycle.
5. RST asserted during the WR of word 0 -> outputs 0 next cycle, and a preloaded SRAM word 1 is unchanged.
6. M=6 -> WPP=2, and the mask for word 1 is 0011.
